wdg_win_core: RTL and testbench
===============================

// Module: wdg_win_core
// PURPOSE
//  Windowed, two-stage watchdog core: next generation of the APB4 watchdog, width-parametrised.
//  Adds a feed window (early feed = fault), an early-warning IRQ stage with grace period,
//  and a timed reset pulse with a sticky cause code. Sits behind an APB4 register shell,
//  which drives the cfg/feed ports and reads the status outputs.
// PARAMETERS
//  CNT_WIDTH   32            width of main counter, cmp_i, win_i, grace_i
//  PSCR_WIDTH  20            width of prescaler divide value
//  KEY         32'h5F37_59DF feed key; feed_key_i must equal KEY for a valid feed
//  RST_LEN     16            rst_o pulse length in clk_i cycles (>=1)
// PORTS
//  clk_i       in   1           clock
//  rst_i       in   1           synchronous reset, active-high
//  en_i        in   1           watchdog enable (level)
//  etr_i       in   1           1: tick from ext_trg_i rising edge, 0: internal prescaler
//  ext_trg_i   in   1           external trigger, already synchronised to clk_i
//  pscr_i      in   PSCR_WIDTH  prescaler: tick every pscr_i+1 clocks
//  win_i       in   CNT_WIDTH   window-open count; feeds before cnt reaches it are early
//  cmp_i       in   CNT_WIDTH   timeout count -> WARN
//  grace_i     in   CNT_WIDTH   ticks spent in WARN before reset
//  feed_i      in   1           single-cycle feed strobe
//  feed_key_i  in   32          key presented with feed_i
//  warn_clr_i  in   1           clears warn_o
//  cause_clr_i in   1           clears cause_o
//  warn_o      out  1           early-warning IRQ, level, sticky
//  rst_o       out  1           system reset request pulse
//  cause_o     out  2           00 none, 01 timeout, 10 early feed, 11 bad key
//  state_o     out  3           FSM state encoding, for status readback
//  cnt_o       out  CNT_WIDTH   current main count
// BEHAVIOUR
//  - Reset (rst_i): state IDLE. All outputs 0; all counters and shadow regs 0.
//  - FSM states: IDLE=0, CLOSED=1, OPEN=2, WARN=3, RESET=4.
//  - Shadow config: pscr/win/cmp/grace are sampled only on the IDLE->run transition.
//    Changes while running are ignored. cmp shadow 0 is treated as 1.
//  - IDLE: when en_i=1, go to CLOSED on the next cycle (OPEN if win shadow is 0).
//    cnt=0 and prescaler=0 on entry.
//  - Tick: with etr_i=0, one clk when the prescaler count equals pscr shadow, after which
//    the prescaler wraps to 0. pscr=0 gives a tick every clk.
//    With etr_i=1, a tick is one clk on each 0->1 of ext_trg_i. etr_i is used live.
//  - CLOSED/OPEN: cnt increments on each tick.
//    CLOSED->OPEN on the tick where cnt+1 >= win. If win >= cmp, OPEN is never entered.
//    On the tick where cnt+1 == cmp: go to WARN, set cnt=0, set warn_o=1 the next cycle.
//  - WARN: grace counter counts ticks. On the tick where it equals grace shadow, go to RESET
//    with cause 01; grace=0 resets on the first tick.
//  - Valid feed = feed_i & (feed_key_i == KEY):
//    - In OPEN or WARN: cnt, grace counter and prescaler clear; go to CLOSED
//      (OPEN if win=0) next cycle. warn_o is not cleared by a feed.
//    - In CLOSED: go to RESET, cause 10.
//  - Any state except IDLE/RESET: feed_i with a wrong key -> RESET, cause 11.
//  - Simultaneous events: feed beats tick in the same cycle; an OPEN feed on the cmp tick
//    does not enter WARN. Reset-causing events beat everything.
//  - RESET: rst_o=1 for exactly RST_LEN cycles, starting the cycle after entry.
//    Then go to IDLE, and re-arm through IDLE if en_i is still 1.
//  - cause_o is written only on entry to RESET, and only if currently 00 (first cause wins).
//    cause_clr_i clears it, and loses to a same-cycle write.
//  - warn_clr_i clears warn_o, and loses to a same-cycle set.
//  - en_i=0 in CLOSED/OPEN/WARN: go to IDLE next cycle, counters clear, warn_o/cause_o kept.
//    en_i=0 is ignored in RESET; the pulse always completes.
//  - Counters saturate-free: cnt never exceeds cmp-1. All compares are unsigned, full width.
// TESTING
//  1. rst_i=1 for 2 clk -> all outputs 0, state_o=0; en_i=1 -> state_o=1 next clk.
//  2. pscr=3, win=4, cmp=8, grace=2, no feed: warn_o rises 33 clk after arm.
//     After 3 more ticks (12 clk): rst_o high 16 clk, cause_o=01.
//  3. Same cfg, valid feed at cnt=5 (OPEN) -> cnt_o=0, state_o=1, no warn_o, no rst_o.
//  4. Valid feed at cnt=2 (CLOSED) -> rst_o next clk, cause_o=10.
//     A timeout during the next run leaves cause_o=10.
//  5. feed_key_i=32'h0 in OPEN -> cause_o=11.
//     Feed on the same clk as the cmp tick in OPEN -> state_o=1, warn_o=0.
//  6. etr_i=1, 5 rising edges of ext_trg_i, cmp=5 -> WARN.
//     en_i=0 in WARN -> IDLE, warn_o stays 1 until warn_clr_i.

Source files
------------

// File: rtl/wdg_win_core.sv
`default_nettype none
// ============================================================================
// Module   : wdg_win_core
// Brief    : Windowed two-stage watchdog: feed window, early-warning IRQ with
//            grace period, timed reset pulse and sticky first-cause code.
// Revision : 1.0
// ============================================================================
module wdg_win_core #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PSCR_WIDTH = 20,
  parameter logic [31:0] KEY        = 32'h5F37_59DF,
  parameter int unsigned RST_LEN    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  etr_i,
  input  logic                  ext_trg_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic [CNT_WIDTH-1:0]  win_i,
  input  logic [CNT_WIDTH-1:0]  cmp_i,
  input  logic [CNT_WIDTH-1:0]  grace_i,
  input  logic                  feed_i,
  input  logic [31:0]           feed_key_i,
  input  logic                  warn_clr_i,
  input  logic                  cause_clr_i,
  output logic                  warn_o,
  output logic                  rst_o,
  output logic [1:0]            cause_o,
  output logic [2:0]            state_o,
  output logic [CNT_WIDTH-1:0]  cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLOSED = 3'd1,
    S_OPEN   = 3'd2,
    S_WARN   = 3'd3,
    S_RESET  = 3'd4
  } state_e;

  localparam int unsigned          c_rcw      = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [c_rcw-1:0]     c_rst_last = c_rcw'(RST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] c_one      = CNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    gcnt_q, gcnt_d;
  logic [PSCR_WIDTH-1:0]   psc_q, psc_d;
  logic [c_rcw-1:0]        rcnt_q, rcnt_d;
  logic [PSCR_WIDTH-1:0]   pscr_q, pscr_d;
  logic [CNT_WIDTH-1:0]    win_q, win_d;
  logic [CNT_WIDTH-1:0]    cmp_q, cmp_d;
  logic [CNT_WIDTH-1:0]    grace_q, grace_d;
  logic                    warn_q, warn_d;
  logic                    rst_q, rst_d;
  logic [1:0]              cause_q, cause_d;
  logic                    trg_q;

  logic                    w_tick;
  logic                    w_feed_ok;
  logic                    w_feed_bad;
  logic [CNT_WIDTH-1:0]    w_cnt_inc;
  state_e                  w_arm_state;
  logic                    w_warn_set;
  logic                    w_cause_set;
  logic [1:0]              w_cause_code;

  assign w_tick      = etr_i ? (ext_trg_i & ~trg_q) : (psc_q == pscr_q);
  assign w_feed_ok   = feed_i & (feed_key_i == KEY);
  assign w_feed_bad  = feed_i & (feed_key_i != KEY);
  assign w_cnt_inc   = cnt_q + c_one;
  assign w_arm_state = (win_q == '0) ? S_OPEN : S_CLOSED;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    psc_d        = psc_q;
    rcnt_d       = rcnt_q;
    pscr_d       = pscr_q;
    win_d        = win_q;
    cmp_d        = cmp_q;
    grace_d      = grace_q;
    rst_d        = rst_q;
    w_warn_set   = 1'b0;
    w_cause_set  = 1'b0;
    w_cause_code = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          pscr_d  = pscr_i;
          win_d   = win_i;
          cmp_d   = (cmp_i == '0) ? c_one : cmp_i;
          grace_d = grace_i;
          state_d = (win_i == '0) ? S_OPEN : S_CLOSED;
          cnt_d   = '0;
          gcnt_d  = '0;
          psc_d   = '0;
        end
      end

      S_CLOSED, S_OPEN, S_WARN: begin
        if (!etr_i) psc_d = w_tick ? '0 : psc_q + 1'b1;

        // Reset-causing events first; a valid feed suppresses the grace timeout tick.
        if (w_feed_bad) begin
          w_cause_set  = 1'b1;
          w_cause_code = 2'b11;
        end else if (w_feed_ok && (state_q == S_CLOSED)) begin
          w_cause_set  = 1'b1;
          w_cause_code = 2'b10;
        end else if ((state_q == S_WARN) && w_tick && !w_feed_ok && (gcnt_q == grace_q)) begin
          w_cause_set  = 1'b1;
          w_cause_code = 2'b01;
        end

        if (w_cause_set) begin
          state_d = S_RESET;
          rst_d   = 1'b1;
          rcnt_d  = '0;
          cnt_d   = '0;
          gcnt_d  = '0;
          psc_d   = '0;
        end else if (!en_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          gcnt_d  = '0;
          psc_d   = '0;
        end else if (w_feed_ok) begin
          state_d = w_arm_state;
          cnt_d   = '0;
          gcnt_d  = '0;
          psc_d   = '0;
        end else if (w_tick) begin
          if (state_q == S_WARN) begin
            gcnt_d = gcnt_q + c_one;
          end else if (w_cnt_inc == cmp_q) begin
            state_d    = S_WARN;
            cnt_d      = '0;
            w_warn_set = 1'b1;
          end else begin
            cnt_d = w_cnt_inc;
            if ((state_q == S_CLOSED) && (w_cnt_inc >= win_q)) state_d = S_OPEN;
          end
        end
      end

      S_RESET: begin
        if (rcnt_q == c_rst_last) begin
          state_d = S_IDLE;
          rst_d   = 1'b0;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Sets win over clears; only the first cause since the last clear is kept.
    warn_d = w_warn_set ? 1'b1 : (warn_clr_i ? 1'b0 : warn_q);
    if (w_cause_set && (cause_q == 2'b00)) cause_d = w_cause_code;
    else if (cause_clr_i)                  cause_d = 2'b00;
    else                                   cause_d = cause_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      psc_q   <= '0;
      rcnt_q  <= '0;
      pscr_q  <= '0;
      win_q   <= '0;
      cmp_q   <= '0;
      grace_q <= '0;
      warn_q  <= 1'b0;
      rst_q   <= 1'b0;
      cause_q <= 2'b00;
      trg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      psc_q   <= psc_d;
      rcnt_q  <= rcnt_d;
      pscr_q  <= pscr_d;
      win_q   <= win_d;
      cmp_q   <= cmp_d;
      grace_q <= grace_d;
      warn_q  <= warn_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
      trg_q   <= ext_trg_i;
    end
  end

  assign warn_o  = warn_q;
  assign rst_o   = rst_q;
  assign cause_o = cause_q;
  assign state_o = state_q;
  assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wdg_win_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdg_win_core
// Brief    : Directed scenarios plus randomized traffic against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_wdg_win_core;

  localparam logic [31:0] KEY     = 32'h5F37_59DF;
  localparam int unsigned RST_LEN = 16;

  logic        clk = 1'b0;
  logic        rst, en, etr, ext_trg, feed, warn_clr, cause_clr;
  logic [19:0] pscr;
  logic [31:0] win, cmp, grace, feed_key;
  logic        warn_o, rst_o;
  logic [1:0]  cause_o;
  logic [2:0]  state_o;
  logic [31:0] cnt_o;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  wdg_win_core #(
    .CNT_WIDTH (32),
    .PSCR_WIDTH(20),
    .KEY       (KEY),
    .RST_LEN   (RST_LEN)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .etr_i      (etr),
    .ext_trg_i  (ext_trg),
    .pscr_i     (pscr),
    .win_i      (win),
    .cmp_i      (cmp),
    .grace_i    (grace),
    .feed_i     (feed),
    .feed_key_i (feed_key),
    .warn_clr_i (warn_clr),
    .cause_clr_i(cause_clr),
    .warn_o     (warn_o),
    .rst_o      (rst_o),
    .cause_o    (cause_o),
    .state_o    (state_o),
    .cnt_o      (cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: watchdog rules evaluated once per clock on plain integers.
  int unsigned m_st, m_cnt, m_psc, m_gr, m_rleft, m_cause;
  int unsigned s_pscr, s_win, s_cmp, s_grace;
  bit          m_warn, m_rst, m_ptrg;

  task automatic model_step();
    bit          tick, good, bad, set_warn;
    int unsigned req;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_psc = 0; m_gr = 0; m_rleft = 0; m_cause = 0;
      s_pscr = 0; s_win = 0; s_cmp = 0; s_grace = 0;
      m_warn = 0; m_rst = 0; m_ptrg = 0;
      return;
    end
    tick     = etr ? (ext_trg && !m_ptrg) : (m_psc == s_pscr);
    m_ptrg   = ext_trg;
    good     = feed && (feed_key == KEY);
    bad      = feed && (feed_key != KEY);
    set_warn = 0;
    req      = 0;
    if (m_st == 0) begin
      if (en) begin
        s_pscr = pscr; s_win = win; s_cmp = (cmp == 0) ? 1 : cmp; s_grace = grace;
        m_st = (s_win == 0) ? 2 : 1;
        m_cnt = 0; m_psc = 0; m_gr = 0;
      end
    end else if (m_st == 4) begin
      m_rleft--;
      if (m_rleft == 0) begin m_st = 0; m_rst = 0; end
    end else begin
      if (!etr) m_psc = tick ? 0 : m_psc + 1;
      if (bad)                                                 req = 3;
      else if (good && m_st == 1)                              req = 2;
      else if (m_st == 3 && tick && !good && m_gr == s_grace)  req = 1;
      if (req != 0) begin
        m_st = 4; m_rst = 1; m_rleft = RST_LEN; m_cnt = 0; m_gr = 0; m_psc = 0;
      end else if (!en) begin
        m_st = 0; m_cnt = 0; m_gr = 0; m_psc = 0;
      end else if (good) begin
        m_st = (s_win == 0) ? 2 : 1; m_cnt = 0; m_gr = 0; m_psc = 0;
      end else if (tick) begin
        if (m_st == 3) m_gr++;
        else if (m_cnt + 1 == s_cmp) begin m_st = 3; m_cnt = 0; set_warn = 1; end
        else begin
          m_cnt++;
          if (m_cnt >= s_win) m_st = 2;
        end
      end
    end
    if (set_warn)      m_warn = 1;
    else if (warn_clr) m_warn = 0;
    if (req != 0 && m_cause == 0) m_cause = req;
    else if (cause_clr)           m_cause = 0;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("mon_state", 32'(state_o), m_st);
      check_eq("mon_cnt",   cnt_o,        m_cnt);
      check_eq("mon_warn",  32'(warn_o),  32'(m_warn));
      check_eq("mon_rst",   32'(rst_o),   32'(m_rst));
      check_eq("mon_cause", 32'(cause_o), m_cause);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; feed = 0; warn_clr = 0; cause_clr = 0; etr = 0; ext_trg = 0;
    feed_key = KEY;
    step(); step();
    rst = 0;
  endtask

  task automatic set_cfg(input int unsigned p, input int unsigned w, input int unsigned c,
                         input int unsigned g);
    pscr = 20'(p); win = w; cmp = c; grace = g;
  endtask

  task automatic wait_cnt(input string tag, input int unsigned tgt, input int bound);
    int i = 0;
    while (cnt_o != tgt && i < bound) begin step(); i++; end
    check_eq(tag, 32'(cnt_o == tgt), 1);
  endtask

  task automatic do_feed(input logic [31:0] key);
    feed = 1; feed_key = key;
    step();
    feed = 0; feed_key = KEY;
  endtask

  initial begin
    int n;
    rst = 1; en = 0; etr = 0; ext_trg = 0; feed = 0; feed_key = KEY;
    warn_clr = 0; cause_clr = 0;
    set_cfg(3, 4, 8, 2);

    // 1: reset state and arm
    step(); mon_en = 1; step();
    check_eq("t1_warn",  32'(warn_o),  0);
    check_eq("t1_rst",   32'(rst_o),   0);
    check_eq("t1_cause", 32'(cause_o), 0);
    check_eq("t1_state", 32'(state_o), 0);
    check_eq("t1_cnt",   cnt_o,        0);
    rst = 0; en = 1;
    step();
    check_eq("t1_arm_state", 32'(state_o), 1);

    // 2: unfed timeout, warn latency, grace, reset pulse length
    do_reset(); set_cfg(3, 4, 8, 2); en = 1;
    n = 0;
    while (!warn_o && n < 100) begin step(); n++; end
    check_eq("t2_warn_lat", n, 33);
    n = 0;
    while (!rst_o && n < 60) begin step(); n++; end
    check_eq("t2_rst_lat", n, 12);
    check_eq("t2_cause", 32'(cause_o), 1);
    n = 0;
    while (rst_o && n < 40) begin step(); n++; end
    check_eq("t2_rst_len", n, RST_LEN);

    // 3: valid feed inside the window
    do_reset(); set_cfg(3, 4, 8, 2); en = 1;
    wait_cnt("t3_reach5", 5, 100);
    check_eq("t3_open", 32'(state_o), 2);
    do_feed(KEY);
    check_eq("t3_cnt",   cnt_o,        0);
    check_eq("t3_state", 32'(state_o), 1);
    check_eq("t3_warn",  32'(warn_o),  0);
    check_eq("t3_rst",   32'(rst_o),   0);

    // 4: early feed, then a later timeout must not overwrite the cause
    do_reset(); set_cfg(3, 4, 8, 2); en = 1;
    wait_cnt("t4_reach2", 2, 100);
    do_feed(KEY);
    check_eq("t4_rst",   32'(rst_o),   1);
    check_eq("t4_cause", 32'(cause_o), 2);
    n = 0;
    while (rst_o && n < 40) begin step(); n++; end
    n = 0;
    while (!rst_o && n < 200) begin step(); n++; end
    check_eq("t4_second_rst", 32'(rst_o), 1);
    check_eq("t4_cause_kept", 32'(cause_o), 2);

    // 5: bad key, then a feed coinciding with the cmp tick
    do_reset(); set_cfg(3, 4, 8, 2); en = 1;
    wait_cnt("t5_reach5", 5, 100);
    do_feed(32'h0);
    check_eq("t5_badkey_cause", 32'(cause_o), 3);
    check_eq("t5_badkey_state", 32'(state_o), 4);
    do_reset(); set_cfg(0, 4, 8, 2); en = 1;
    wait_cnt("t5_reach7", 7, 50);
    do_feed(KEY);
    check_eq("t5_cmpfeed_state", 32'(state_o), 1);
    check_eq("t5_cmpfeed_warn",  32'(warn_o),  0);

    // 6: external trigger ticks, disable in WARN, warn clear
    do_reset(); set_cfg(3, 2, 5, 10); etr = 1; en = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      ext_trg = 1; step(); step();
      ext_trg = 0; step(); step();
    end
    check_eq("t6_state_warn", 32'(state_o), 3);
    check_eq("t6_warn",       32'(warn_o),  1);
    en = 0;
    step();
    check_eq("t6_idle",      32'(state_o), 0);
    check_eq("t6_warn_kept", 32'(warn_o),  1);
    warn_clr = 1; step(); warn_clr = 0;
    check_eq("t6_warn_clr", 32'(warn_o), 0);

    // Randomized traffic, checked cycle by cycle by the monitor
    do_reset();
    set_cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12),
            $urandom_range(0, 4));
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) etr = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12),
                $urandom_range(0, 4));
      rst       = ($urandom_range(0, 399) == 0);
      en        = ($urandom_range(0, 99) != 0);
      ext_trg   = $urandom_range(0, 1) == 1;
      feed      = ($urandom_range(0, 9) == 0);
      feed_key  = ($urandom_range(0, 9) == 0) ? $urandom : KEY;
      warn_clr  = ($urandom_range(0, 19) == 0);
      cause_clr = ($urandom_range(0, 29) == 0);
      step();
    end
    rst = 0; feed = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
